// File: rtl/tile_skew_packer.sv
// tile_skew_packer: fetches one TILE_N x TILE_N tile of a zero-padded image through the
// request/response pixel handshake, then writes it to the tile SRAM as 2*TILE_N-1
// anti-diagonal words (lane r of word k holds tile[r][k-r]).
// Optional build macro: TILE_PACK_CHAN_LOOP_EN -- one start walks channels 0..cfg_img_c-1.
module tile_skew_packer #(
    parameter int unsigned TILE_N     = 9,
    parameter int unsigned PIX_W      = 4,
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned NUM_WMASKS = 8,
    parameter int unsigned SRAM_DEPTH = 1024,
    parameter int unsigned SRAM_WAIT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_W-1:0]    cfg_org_x,
    input  logic [COORD_W-1:0]    cfg_org_y,
    input  logic [COORD_W-1:0]    cfg_z,
    input  logic [COORD_W-1:0]    cfg_img_h,
    input  logic [COORD_W-1:0]    cfg_img_w,
    input  logic [COORD_W-1:0]    cfg_img_c,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [COORD_W-1:0]    x,
    output logic [COORD_W-1:0]    y,
    output logic [COORD_W-1:0]    z,
    input  logic                  rsp_valid,
    input  logic [PIX_W-1:0]      rsp_pixel,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_din,
    output logic                  sram_csb_n,
    output logic                  sram_web_n,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned IDX_W     = (TILE_N > 1) ? $clog2(TILE_N) : 1;
    localparam int unsigned NUM_WORDS = 2 * TILE_N - 1;
    localparam int unsigned K_W       = $clog2(2 * TILE_N);
    localparam int unsigned WAIT_W    = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_RSP   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_REL   = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    generate
        if (DATA_W < TILE_N * PIX_W) begin : g_bad_data_w
            $error("tile_skew_packer: DATA_W must be >= TILE_N*PIX_W");
        end
    endgenerate

    typedef logic [TILE_N-1:0][TILE_N-1:0][PIX_W-1:0] tile_t;

    // Anti-diagonal word k: lane r carries tile[r][k-r], lanes off the diagonal are zero.
    function automatic logic [DATA_W-1:0] pack_word(input tile_t t, input logic [K_W-1:0] k);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int r = 0; r < TILE_N; r++) begin
            for (int c = 0; c < TILE_N; c++) begin
                if (int'(k) == r + c) w[r*PIX_W +: PIX_W] = t[r][c];
            end
        end
        return w;
    endfunction

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    r_q, r_d, c_q, c_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_next;
    tile_t               tile_q, tile_d;
    logic [COORD_W-1:0]  org_x_q, org_x_d, org_y_q, org_y_d;
    logic [COORD_W-1:0]  img_h_q, img_h_d, img_w_q, img_w_d, chan_q, chan_d;
    logic                req_valid_d, csb_d, web_d, busy_d, done_d;
    logic [COORD_W-1:0]  x_d, y_d, z_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   din_d;
    logic signed [COORD_W:0] row_s, col_s;
    logic                in_img, elem_done, enter_rel;
    logic                unused_cfg;

`ifdef TILE_PACK_CHAN_LOOP_EN
    logic [COORD_W-1:0]      img_c_q, img_c_d;
    logic signed [COORD_W:0] chan_nx;
    assign unused_cfg = ^cfg_z;
`else
    assign unused_cfg = ^cfg_img_c;
`endif

    assign ptr_next = (ptr_q == ADDR_W'(SRAM_DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);

    // Next-state and next-output logic for fetch walk and word write sequencing.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        k_d         = k_q;
        wait_d      = wait_q;
        ptr_d       = ptr_q;
        tile_d      = tile_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        img_h_d     = img_h_q;
        img_w_d     = img_w_q;
        chan_d      = chan_q;
        req_valid_d = req_valid;
        x_d         = x;
        y_d         = y;
        z_d         = z;
        addr_d      = sram_addr;
        din_d       = sram_din;
        csb_d       = sram_csb_n;
        web_d       = sram_web_n;
        busy_d      = busy;
        done_d      = 1'b0;
        elem_done   = 1'b0;
        enter_rel   = 1'b0;
`ifdef TILE_PACK_CHAN_LOOP_EN
        img_c_d     = img_c_q;
        chan_nx     = $signed({chan_q[COORD_W-1], chan_q}) + $signed((COORD_W+1)'(1));
`endif
        // org + index is formed one bit wider so large origins cannot wrap into the image.
        row_s  = $signed({org_x_q[COORD_W-1], org_x_q}) + $signed({1'b0, COORD_W'(r_q)});
        col_s  = $signed({org_y_q[COORD_W-1], org_y_q}) + $signed({1'b0, COORD_W'(c_q)});
        in_img = !row_s[COORD_W] && !col_s[COORD_W]
                 && (row_s < $signed({img_h_q[COORD_W-1], img_h_q}))
                 && (col_s < $signed({img_w_q[COORD_W-1], img_w_q}));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    org_x_d = cfg_org_x;
                    org_y_d = cfg_org_y;
                    img_h_d = cfg_img_h;
                    img_w_d = cfg_img_w;
`ifdef TILE_PACK_CHAN_LOOP_EN
                    chan_d  = '0;
                    img_c_d = cfg_img_c;
`else
                    chan_d  = cfg_z;
`endif
                    r_d     = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (in_img) begin
                    state_d     = ST_REQ;
                    req_valid_d = 1'b1;
                    x_d         = row_s[COORD_W-1:0];
                    y_d         = col_s[COORD_W-1:0];
                    z_d         = chan_q;
                end else begin
                    tile_d[r_q][c_q] = '0;
                    elem_done        = 1'b1;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid) begin
                    tile_d[r_q][c_q] = rsp_pixel;
                    elem_done        = 1'b1;
                end
            end
            ST_WRITE: begin
                if (SRAM_WAIT == 0) begin
                    enter_rel = 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wait_q == WAIT_W'(SRAM_WAIT - 1)) enter_rel = 1'b1;
                else wait_d = wait_q + WAIT_W'(1);
            end
            ST_REL: begin
                if (k_q == K_W'(NUM_WORDS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`ifdef TILE_PACK_CHAN_LOOP_EN
                    if (chan_nx < $signed({img_c_q[COORD_W-1], img_c_q})) begin
                        chan_d  = chan_nx[COORD_W-1:0];
                        r_d     = '0;
                        c_d     = '0;
                        state_d = ST_CHECK;
                        done_d  = 1'b0;
                    end
`endif
                end else begin
                    state_d = ST_WRITE;
                    addr_d  = ptr_q;
                    din_d   = pack_word(tile_q, k_q);
                    csb_d   = 1'b0;
                    web_d   = 1'b0;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Advance the raster walk; the last element launches word 0 from the updated tile.
        if (elem_done) begin
            if (r_q == IDX_W'(TILE_N - 1) && c_q == IDX_W'(TILE_N - 1)) begin
                state_d = ST_WRITE;
                k_d     = '0;
                addr_d  = ptr_q;
                din_d   = pack_word(tile_d, K_W'(0));
                csb_d   = 1'b0;
                web_d   = 1'b0;
            end else begin
                state_d = ST_CHECK;
                if (c_q == IDX_W'(TILE_N - 1)) begin
                    c_d = '0;
                    r_d = r_q + IDX_W'(1);
                end else begin
                    c_d = c_q + IDX_W'(1);
                end
            end
        end

        // Release the strobes and step to the next word and address.
        if (enter_rel) begin
            state_d = ST_REL;
            csb_d   = 1'b1;
            web_d   = 1'b1;
            ptr_d   = ptr_next;
            k_d     = k_q + K_W'(1);
        end
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            wait_q     <= '0;
            ptr_q      <= '0;
            tile_q     <= '0;
            org_x_q    <= '0;
            org_y_q    <= '0;
            img_h_q    <= '0;
            img_w_q    <= '0;
            chan_q     <= '0;
`ifdef TILE_PACK_CHAN_LOOP_EN
            img_c_q    <= '0;
`endif
            req_valid  <= 1'b0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_csb_n <= 1'b1;
            sram_web_n <= 1'b1;
            sram_wmask <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            tile_q     <= tile_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            img_h_q    <= img_h_d;
            img_w_q    <= img_w_d;
            chan_q     <= chan_d;
`ifdef TILE_PACK_CHAN_LOOP_EN
            img_c_q    <= img_c_d;
`endif
            req_valid  <= req_valid_d;
            x          <= x_d;
            y          <= y_d;
            z          <= z_d;
            sram_addr  <= addr_d;
            sram_din   <= din_d;
            sram_csb_n <= csb_d;
            sram_web_n <= web_d;
            sram_wmask <= '1;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
